// File: rtl/me_search_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : me_search_scheduler
//  Description : Full-search block-matching sequencer for the motion-
//                estimation SAD datapath. Walks a clipped candidate window
//                in raster order (x fastest), issuing one candidate at a
//                time and tracking the minimum SAD and its motion vector.
//  Ports       : clk, rst_n (sync, active-high)   clock / reset
//                start, abort                     search control
//                clip_{x,y}_{min,max}             candidate window bounds
//                dp_start, cand_x, cand_y         issue to the datapath
//                dp_valid, dp_sad                 result from the datapath
//                busy, done, err                  status
//                best_sad, best_mv_x/y,           search result
//                cand_count
//  Revision    : 1.0  initial release
// ============================================================================
module me_search_scheduler #(
    parameter  int MACRO_DIM  = 16,
    parameter  int SEARCH_DIM = 48,
    parameter  int SAD_W      = 16,
    localparam int NUM_POS    = SEARCH_DIM - MACRO_DIM + 1,
    localparam int POS_W      = $clog2(NUM_POS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [POS_W-1:0] clip_x_min,
    input  logic [POS_W-1:0] clip_x_max,
    input  logic [POS_W-1:0] clip_y_min,
    input  logic [POS_W-1:0] clip_y_max,
    output logic             dp_start,
    output logic [POS_W-1:0] cand_x,
    output logic [POS_W-1:0] cand_y,
    input  logic             dp_valid,
    input  logic [SAD_W-1:0] dp_sad,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SAD_W-1:0] best_sad,
    output logic [POS_W-1:0] best_mv_x,
    output logic [POS_W-1:0] best_mv_y,
    output logic [10:0]      cand_count
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_CHECK  = 3'd1;
    localparam logic [2:0] c_S_ISSUE  = 3'd2;
    localparam logic [2:0] c_S_WAIT   = 3'd3;
    localparam logic [2:0] c_S_FINISH = 3'd4;

    localparam logic [POS_W-1:0] c_MAX_POS  = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0] c_CENTER   = POS_W'((NUM_POS - 1) / 2);
    localparam logic [POS_W-1:0] c_POS_ONE  = POS_W'(1);
    localparam logic [SAD_W-1:0] c_SAD_INIT = '1;
    localparam logic [10:0]      c_CNT_MAX  = 11'h7FF;

    logic [2:0]       r_state;
    logic             r_dp_start;
    logic             r_err;
    logic [POS_W-1:0] r_cand_x;
    logic [POS_W-1:0] r_cand_y;
    logic [POS_W-1:0] r_x_min;
    logic [POS_W-1:0] r_x_max;
    logic [POS_W-1:0] r_y_min;
    logic [POS_W-1:0] r_y_max;
    logic [SAD_W-1:0] r_best_sad;
    logic [POS_W-1:0] r_best_mv_x;
    logic [POS_W-1:0] r_best_mv_y;
    logic [10:0]      r_cand_count;

    logic w_window_bad;
    logic w_row_end;
    logic w_last_cand;
    logic w_better;

    assign w_window_bad = (r_x_min > r_x_max) || (r_y_min > r_y_max) ||
                          (r_x_max > c_MAX_POS) || (r_y_max > c_MAX_POS);
    assign w_row_end    = !(r_cand_x < r_x_max);
    assign w_last_cand  = (r_cand_x == r_x_max) && (r_cand_y == r_y_max);
    // Strict compare: on a tie the earlier raster candidate is kept.
    assign w_better     = (dp_sad < r_best_sad);

    // Note: the port named rst_n is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state      <= c_S_IDLE;
            r_dp_start   <= 1'b0;
            r_err        <= 1'b0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_x_min      <= '0;
            r_x_max      <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_best_sad   <= c_SAD_INIT;
            r_best_mv_x  <= '0;
            r_best_mv_y  <= '0;
            r_cand_count <= '0;
        end else begin
            r_dp_start <= 1'b0;
            // Abort beats everything, including a result arriving in the
            // same cycle; best_* and cand_count are left frozen.
            if (abort && (r_state != c_S_IDLE)) begin
                r_state <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (start) begin
                            r_x_min      <= clip_x_min;
                            r_x_max      <= clip_x_max;
                            r_y_min      <= clip_y_min;
                            r_y_max      <= clip_y_max;
                            r_best_sad   <= c_SAD_INIT;
                            r_best_mv_x  <= '0;
                            r_best_mv_y  <= '0;
                            r_cand_count <= '0;
                            r_err        <= 1'b0;
                            r_state      <= c_S_CHECK;
                        end
                    end
                    c_S_CHECK: begin
                        if (w_window_bad) begin
                            r_err       <= 1'b1;
                            r_best_sad  <= c_SAD_INIT;
                            r_best_mv_x <= '0;
                            r_best_mv_y <= '0;
                            r_state     <= c_S_FINISH;
                        end else begin
                            r_cand_x <= r_x_min;
                            r_cand_y <= r_y_min;
                            r_state  <= c_S_ISSUE;
                        end
                    end
                    c_S_ISSUE: begin
                        // Registered pulse: visible in the first WAIT cycle.
                        r_dp_start <= 1'b1;
                        r_state    <= c_S_WAIT;
                    end
                    c_S_WAIT: begin
                        if (dp_valid) begin
                            if (r_cand_count != c_CNT_MAX) begin
                                r_cand_count <= r_cand_count + 11'd1;
                            end
                            if (w_better) begin
                                r_best_sad  <= dp_sad;
                                r_best_mv_x <= r_cand_x - c_CENTER;
                                r_best_mv_y <= r_cand_y - c_CENTER;
                            end
                            // A zero SAD cannot be beaten: stop early.
                            if ((dp_sad == '0) || w_last_cand) begin
                                r_state <= c_S_FINISH;
                            end else begin
                                if (w_row_end) begin
                                    r_cand_x <= r_x_min;
                                    r_cand_y <= r_cand_y + c_POS_ONE;
                                end else begin
                                    r_cand_x <= r_cand_x + c_POS_ONE;
                                end
                                r_state <= c_S_ISSUE;
                            end
                        end
                    end
                    c_S_FINISH: begin
                        r_state <= c_S_IDLE;
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dp_start   = r_dp_start;
    assign cand_x     = r_cand_x;
    assign cand_y     = r_cand_y;
    assign busy       = (r_state == c_S_CHECK) || (r_state == c_S_ISSUE) ||
                        (r_state == c_S_WAIT);
    assign done       = (r_state == c_S_FINISH);
    assign err        = r_err;
    assign best_sad   = r_best_sad;
    assign best_mv_x  = r_best_mv_x;
    assign best_mv_y  = r_best_mv_y;
    assign cand_count = r_cand_count;

endmodule
`default_nettype wire

// File: doc/me_search_scheduler.md
Name: me_search_scheduler

Overview:
Sequences a full-search block-matching pass of the motion-estimation SAD datapath over a clipped candidate window. It issues one candidate position at a time to the datapath and waits for that candidate's SAD result. It tracks the minimum SAD and its motion vector, then reports the winner with a done pulse. It sits between the macroblock-level encoder control and the ME datapath, which is driven through the dp_* handshake.

Parameters:
MACRO_DIM, 16, macroblock edge in pixels
SEARCH_DIM, 48, search-window edge in pixels
SAD_W, 16, SAD result width
NUM_POS, SEARCH_DIM-MACRO_DIM+1 (33), candidate positions per axis (derived, localparam)
POS_W, $clog2(NUM_POS) (6), candidate coordinate width (derived, localparam)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous, active-high reset
start  input  1  begin a search; sampled only in IDLE
abort  input  1  cancel the current search; returns to IDLE
clip_x_min  input  POS_W  first allowed candidate column
clip_x_max  input  POS_W  last allowed candidate column
clip_y_min  input  POS_W  first allowed candidate row
clip_y_max  input  POS_W  last allowed candidate row
dp_start  output  1  one-cycle pulse, launches the SAD for cand_x/cand_y
cand_x  output  POS_W  current candidate column, held until the next issue
cand_y  output  POS_W  current candidate row, held until the next issue
dp_valid  input  1  datapath result strobe
dp_sad  input  SAD_W  SAD of the outstanding candidate, valid with dp_valid
busy  output  1  high from the cycle after start until done or abort
done  output  1  one-cycle completion pulse
err  output  1  clip window invalid; valid with done
best_sad  output  SAD_W  minimum SAD found
best_mv_x  output  POS_W signed  best column minus (NUM_POS-1)/2; range -16..+16
best_mv_y  output  POS_W signed  best row minus (NUM_POS-1)/2
cand_count  output  11  number of results accepted in this search

Behaviour:
- Reset: state IDLE. dp_start=0, busy=0, done=0, err=0, cand_x=cand_y=0, best_sad=all ones, best_mv_x=best_mv_y=0, cand_count=0.
- States: IDLE, CHECK, ISSUE, WAIT, FINISH.
- IDLE:
  - start=1 latches the four clip inputs and sets best_sad to all ones, cand_count to 0, err to 0.
  - Next state is CHECK.
- CHECK (1 cycle):
  - The window is invalid if x_min>x_max, y_min>y_max, x_max>NUM_POS-1 or y_max>NUM_POS-1.
  - Invalid: set err=1, mv=0, best_sad all ones, go to FINISH.
  - Valid: cand_x=x_min, cand_y=y_min, go to ISSUE.
- ISSUE (1 cycle): dp_start=1, then go to WAIT. Only one candidate is outstanding at a time.
- WAIT:
  - Remains until dp_valid=1.
  - On dp_valid, if dp_sad < best_sad (strict), update best_sad and the mv from cand_x/cand_y. Ties keep the earlier candidate in raster order, row-major with x fastest.
  - cand_count increments on every accepted result.
  - Advance: if cand_x<x_max, then cand_x+1. Otherwise cand_x=x_min and cand_y+1.
  - Go to ISSUE, or to FINISH if the accepted candidate was (x_max, y_max).
  - Early termination: if dp_sad==0, record it and go to FINISH immediately.
- FINISH (1 cycle): done=1, then go to IDLE. busy=0 in this cycle.
- Best outputs hold their values from done until the next accepted start.
- Per-candidate cost is 2+L cycles, where L is the number of cycles dp_valid lags dp_start. Full window with L=1: 33*33*3 + 2 cycles from start to done.
- dp_valid outside WAIT is ignored. start while busy is ignored.
- abort: has priority over every other event in any non-IDLE state. Next state is IDLE, no done pulse, best_* and cand_count frozen at their current values, busy=0 next cycle.
- abort and dp_valid in the same cycle: abort wins and the result is discarded.
- rst_n mid-search: identical to the reset values above, including best_sad all ones.
- Arithmetic:
  - mv = cand - 16 in POS_W-bit two's complement.
  - cand_count saturates at 2047. It cannot overflow for defaults, whose maximum is 1089.

Test Plan:
- Full window 0..32 both axes; datapath model L=3 returns SAD=1000 everywhere except (20,9)=37 -> done after 1089 results; best_sad=37; mv=(+4,-7); cand_count=1089; busy low on the done cycle.
- Clip x 10..12, y 5..6; all SAD=500 except (11,6)=500 and (10,5)=500 -> tie keeps (10,5); mv=(-6,-11); cand_count=6; exactly six dp_start pulses, in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6).
- Full window; SAD=0 returned at the 4th candidate (3,0) -> done 1 cycle later; cand_count=4; best_sad=0; mv=(-13,-16); no further dp_start.
- Clip x_min=20, x_max=15 -> done 2 cycles after start with err=1, best_sad=16'hFFFF, mv=(0,0), no dp_start; repeat with x_max=33 -> same result.
- abort asserted in WAIT together with dp_valid carrying SAD=5 after 10 results -> IDLE next cycle, no done, cand_count=10, best_sad unchanged; a new start then runs normally.
- rst_n asserted mid-search for 1 cycle -> all outputs at their reset values; spurious dp_valid and a start while busy in later cycles have no effect.
